// File: rtl/pixel_packer.sv
// pixel_packer: packs a stream of 16-bit pixels into 256-bit DMEM words.
// Sixteen pixels fill one word, with pixel k of the word in bits [16k+15:16k].
// Each word goes out on DMEM port B as a single-cycle write strobe. A final
// partial word is written with its unused lanes zeroed.
module pixel_packer #(
  parameter int NUM_PIXELS = 784,
  parameter int BASE_ADDR  = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         pxl_valid,
  input  logic [15:0]  pxl_data,
  output logic         pxl_ready,
  output logic         dmem_wren,
  output logic [6:0]   dmem_wraddr,
  output logic [255:0] dmem_wrdata,
  output logic         busy,
  output logic         done,
  output logic         overrun
);

  localparam logic [10:0] LAST_IDX = 11'(NUM_PIXELS - 1);
  localparam logic [6:0]  BASE     = 7'(BASE_ADDR);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t         state_reg;
  logic [10:0]    pix_cnt_reg;
  logic [3:0]     lane_reg;
  logic [6:0]     addr_reg;
  logic [255:0]   word_reg;
  logic [255:0]   word_next;
  logic           accept;
  logic           last_pix;
  logic           word_full;

  // Ready and busy are pure decodes of the state register, so they are glitch-free.
  assign pxl_ready = (state_reg == FILL);
  assign busy      = (state_reg == FILL);
  assign accept    = pxl_valid && (state_reg == FILL);
  assign last_pix  = (pix_cnt_reg == LAST_IDX);
  assign word_full = (lane_reg == 4'd15);

  // The word under construction, with the incoming pixel merged into its lane.
  // Lanes that have not been written yet hold zero, because word_reg is cleared
  // whenever a word is emitted. This zero-pads a partial final word for free.
  for (genvar gi = 0; gi < 16; gi++) begin : g_lane
    assign word_next[16*gi +: 16] = (accept && (lane_reg == 4'(gi))) ? pxl_data
                                                                     : word_reg[16*gi +: 16];
  end

  // Frame FSM, including word emission, address stepping and the sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      pix_cnt_reg <= '0;
      lane_reg    <= '0;
      addr_reg    <= '0;
      word_reg    <= '0;
      dmem_wren   <= 1'b0;
      dmem_wraddr <= '0;
      dmem_wrdata <= '0;
      done        <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      dmem_wren <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          // A pixel offered while not ready is dropped and flagged.
          // When start arrives in the same cycle, the clear below wins.
          if (pxl_valid) overrun <= 1'b1;
          if (start) begin
            state_reg   <= FILL;
            done        <= 1'b0;
            overrun     <= 1'b0;
            pix_cnt_reg <= '0;
            lane_reg    <= '0;
            addr_reg    <= BASE;
            word_reg    <= '0;
          end
        end
        FILL: begin
          if (accept) begin
            pix_cnt_reg <= pix_cnt_reg + 11'd1;
            lane_reg    <= lane_reg + 4'd1;
            if (word_full || last_pix) begin
              dmem_wren   <= 1'b1;
              dmem_wrdata <= word_next;
              dmem_wraddr <= addr_reg;
              addr_reg    <= addr_reg + 7'd1;
              word_reg    <= '0;
            end else begin
              word_reg <= word_next;
            end
            if (last_pix) begin
              state_reg <= DONE;
              done      <= 1'b1;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
